idecode_pipe: RTL
=================

# idecode_pipe

Parametrised, registered instruction-decode stage for the RV32I/RV32E core. Holds the architectural register file (two write ports: writeback and return-address), reads and forwards both source operands, decodes every RV32I immediate format, detects load-use hazards with a one-bubble interlock, and presents the decoded bundle to execute through a valid/ready output register. It sits between the fetch stage (upstream handshake) and the execute stage (downstream handshake).

## Interface
- NB_WORD, 32, register/operand/immediate width (≥32)
- NUM_REGS, 32, architectural registers; 32 (RV32I) or 16 (RV32E)
- NB_ADDR, 32, return-address width; zero-extended to NB_WORD on write
- Clocking: one clock; reset is asynchronous and active-high.
- i_clock  in  1  stage clock; all state on posedge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage accepts i_instruction this cycle
- i_instruction  in  32  raw instruction
- i_flush  in  1  discard output slot and load shadow
- i_forward_rs1, i_forward_rs2  in  2 each  00 RF, 01 ALU, 10 MEM, 11 RF
- i_alu_result, i_mem_result  in  NB_WORD each  forwarding sources
- i_wr_retaddr  in  1  return-address write enable
- i_rd_retaddr  in  5  return-address destination
- i_ret_addr  in  NB_ADDR  return address value
- i_write  in  1  writeback enable
- i_wr_addr  in  5  writeback destination
- i_wr_value  in  NB_WORD  writeback value
- o_valid  out  1  output bundle valid
- i_ready  in  1  execute consumes bundle
- o_op1, o_op2, o_imm  out  NB_WORD each  operands, sign-extended immediate
- o_rd  out  5  destination register
- o_opcode  out  7  instruction opcode
- o_illegal  out  1  rs1/rs2/rd index ≥ NUM_REGS
- o_hazard  out  1  load-use bubble being inserted this cycle

## Operation
- RF: NUM_REGS × NB_WORD; x0 reads 0, writes to x0 ignored; writes to index ≥ NUM_REGS ignored.
- Both write ports same nonzero address same cycle: writeback (i_wr_value) wins.
- Read is combinational with write-through: reading a register written this cycle returns the new value (writeback priority applies).
- Forward mux per operand as in i_forward_*; 11 behaves as 00.
- Source usage: rs1 unused for LUI, AUIPC, JAL; rs2 used only for OP, STORE, BRANCH. Unused operands output 0.
- Immediate: I for OP_IMM/LOAD/JALR/SYSTEM/other; S for STORE; B for BRANCH (bit0=0); U for LUI and AUIPC (imm[31:12], low 12 zero); J for JAL (bit0=0); OP gives 0. All sign-extended to NB_WORD.
- Load shadow: capturing a LOAD with rd≠0 sets ld_pending, ld_rd=rd.
- Hazard = i_valid && ld_pending && ((rs1 used && rs1==ld_rd) || (rs2 used && rs2==ld_rd)).
- adv = !o_valid || i_ready. o_ready = adv && !hazard && !i_flush. o_hazard = hazard && adv.
- On adv && !i_flush: if i_valid && !hazard capture bundle, o_valid←1; else o_valid←0 (bubble). ld_pending cleared unless a LOAD with rd≠0 is captured.
- !adv: output and ld_pending hold, payload stable.
- i_flush (priority over all): o_valid←0, ld_pending←0, no capture; RF writes still occur.

## Timing
- Reset (async): RF all 0, o_valid=0, o_op1/o_op2/o_imm=0, o_rd=0, o_opcode=0, o_illegal=0, ld_pending=0; o_ready=1 after reset released.
- Decode latency 1 cycle: instruction accepted at edge N is valid at o_* after edge N.
- RF writes commit at posedge; forwarding inputs and write-through sampled at capture edge.
- Load-use: exactly one bubble cycle, dependent instruction accepted on the next adv cycle.
- Reset mid-stall: bundle and shadow dropped immediately.

## Test plan
- Reset, write x5=0x1234 via i_write, decode ADD x1,x5,x0 -> o_op1=0x1234, o_op2=0, o_valid one cycle later.
- Same-cycle i_write x7=0xAA and i_wr_retaddr x7=0xBB while decoding use of x7 -> o_op1=0xAA; x0 writes leave x0=0.
- LW x3 then ADD x4,x3,x3 back-to-back -> o_hazard=1, one bubble (o_valid=0), ADD issued next cycle; LW then LUI x3 -> no bubble.
- i_ready=0 for 3 cycles with o_valid=1 -> outputs stable, o_ready=0; release -> next instruction captured.
- Immediates: SW imm -4 -> 0xFFFFFFFC; BEQ offset -8 -> 0xFFFFFFF8; LUI 0x12345 and AUIPC 0x12345 -> 0x12345000; JAL +2048 -> 0x00000800.
- NUM_REGS=16: ADD x17,x1,x2 -> o_illegal=1; i_flush during stall -> o_valid=0 next cycle, ld_pending cleared.

Source files
------------

// File: rtl/idecode_pipe.sv
`default_nettype none
// ============================================================================
// idecode_pipe : RV32I/RV32E decode stage - register file, operand forwarding,
//                immediate decode, load-use interlock, valid/ready output reg.
// Revision     : 1.0
// ============================================================================
module idecode_pipe #(
    parameter int NB_WORD  = 32,
    parameter int NUM_REGS = 32,
    parameter int NB_ADDR  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instruction,
    input  logic               i_flush,
    input  logic [1:0]         i_forward_rs1,
    input  logic [1:0]         i_forward_rs2,
    input  logic [NB_WORD-1:0] i_alu_result,
    input  logic [NB_WORD-1:0] i_mem_result,
    input  logic               i_wr_retaddr,
    input  logic [4:0]         i_rd_retaddr,
    input  logic [NB_ADDR-1:0] i_ret_addr,
    input  logic               i_write,
    input  logic [4:0]         i_wr_addr,
    input  logic [NB_WORD-1:0] i_wr_value,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_WORD-1:0] o_op1,
    output logic [NB_WORD-1:0] o_op2,
    output logic [NB_WORD-1:0] o_imm,
    output logic [4:0]         o_rd,
    output logic [6:0]         o_opcode,
    output logic               o_illegal,
    output logic               o_hazard
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [5:0] c_NUM_REGS_W = 6'(NUM_REGS);

    function automatic logic f_in_range(input logic [4:0] idx);
        return ({1'b0, idx} < c_NUM_REGS_W);
    endfunction

    logic [6:0]         w_opc;
    logic [4:0]         w_rd, w_rs1, w_rs2;
    logic               w_use1, w_use2, w_is_load, w_hazard, w_adv, w_illegal;
    logic [NB_WORD-1:0] w_ret_ext, w_rf1, w_rf2, w_opnd1, w_opnd2, w_imm;
    logic [31:0]        w_imm32;
    logic [NB_WORD-1:0] w_rf [32];

    logic               valid_q, valid_d, ld_pending_q, ld_pending_d, illegal_q, illegal_d;
    logic [4:0]         ld_rd_q, ld_rd_d, rd_q, rd_d;
    logic [6:0]         opcode_q, opcode_d;
    logic [NB_WORD-1:0] op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;

    assign w_opc     = i_instruction[6:0];
    assign w_rd      = i_instruction[11:7];
    assign w_rs1     = i_instruction[19:15];
    assign w_rs2     = i_instruction[24:20];
    assign w_ret_ext = NB_WORD'(i_ret_addr);

    // Only x1..x(NUM_REGS-1) hold storage; x0 and nonexistent registers read 0.
    genvar gi;
    for (gi = 0; gi < 32; gi++) begin : g_rf
        if (gi > 0 && gi < NUM_REGS) begin : g_reg
            logic [NB_WORD-1:0] rf_q;
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset)
                    rf_q <= '0;
                else if (i_write && i_wr_addr == 5'(gi))
                    rf_q <= i_wr_value;
                else if (i_wr_retaddr && i_rd_retaddr == 5'(gi))
                    rf_q <= w_ret_ext;
            end
            assign w_rf[gi] = rf_q;
        end else begin : g_zero
            assign w_rf[gi] = '0;
        end
    end

    // Write-through read: writeback overrides return-address on the same index.
    always_comb begin
        w_rf1 = w_rf[w_rs1];
        if (i_wr_retaddr && i_rd_retaddr == w_rs1) w_rf1 = w_ret_ext;
        if (i_write && i_wr_addr == w_rs1)         w_rf1 = i_wr_value;
        if (w_rs1 == 5'd0 || !f_in_range(w_rs1))   w_rf1 = '0;
        case (i_forward_rs1)
            2'b01:   w_opnd1 = i_alu_result;
            2'b10:   w_opnd1 = i_mem_result;
            default: w_opnd1 = w_rf1;
        endcase
        if (!w_use1) w_opnd1 = '0;
    end

    always_comb begin
        w_rf2 = w_rf[w_rs2];
        if (i_wr_retaddr && i_rd_retaddr == w_rs2) w_rf2 = w_ret_ext;
        if (i_write && i_wr_addr == w_rs2)         w_rf2 = i_wr_value;
        if (w_rs2 == 5'd0 || !f_in_range(w_rs2))   w_rf2 = '0;
        case (i_forward_rs2)
            2'b01:   w_opnd2 = i_alu_result;
            2'b10:   w_opnd2 = i_mem_result;
            default: w_opnd2 = w_rf2;
        endcase
        if (!w_use2) w_opnd2 = '0;
    end

    always_comb begin
        case (w_opc)
            c_OPC_OP:     w_imm32 = 32'd0;
            c_OPC_STORE:  w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
            c_OPC_BRANCH: w_imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                                     i_instruction[30:25], i_instruction[11:8], 1'b0};
            c_OPC_LUI,
            c_OPC_AUIPC:  w_imm32 = {i_instruction[31:12], 12'd0};
            c_OPC_JAL:    w_imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                                     i_instruction[20], i_instruction[30:21], 1'b0};
            default:      w_imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
        endcase
    end
    assign w_imm = NB_WORD'($signed(w_imm32));

    assign w_use1    = !(w_opc == c_OPC_LUI || w_opc == c_OPC_AUIPC || w_opc == c_OPC_JAL);
    assign w_use2    = (w_opc == c_OPC_OP || w_opc == c_OPC_STORE || w_opc == c_OPC_BRANCH);
    assign w_is_load = (w_opc == c_OPC_LOAD);
    assign w_illegal = !f_in_range(w_rs1) || !f_in_range(w_rs2) || !f_in_range(w_rd);
    assign w_hazard  = i_valid && ld_pending_q &&
                       ((w_use1 && w_rs1 == ld_rd_q) || (w_use2 && w_rs2 == ld_rd_q));
    assign w_adv     = !valid_q || i_ready;
    assign o_ready   = w_adv && !w_hazard && !i_flush;
    assign o_hazard  = w_hazard && w_adv;

    always_comb begin
        valid_d      = valid_q;
        ld_pending_d = ld_pending_q;
        ld_rd_d      = ld_rd_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        imm_d        = imm_q;
        rd_d         = rd_q;
        opcode_d     = opcode_q;
        illegal_d    = illegal_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            ld_pending_d = 1'b0;
        end else if (w_adv) begin
            if (i_valid && !w_hazard) begin
                valid_d      = 1'b1;
                ld_pending_d = w_is_load && (w_rd != 5'd0);
                ld_rd_d      = w_rd;
                op1_d        = w_opnd1;
                op2_d        = w_opnd2;
                imm_d        = w_imm;
                rd_d         = w_rd;
                opcode_d     = w_opc;
                illegal_d    = w_illegal;
            end else begin
                valid_d      = 1'b0;
                ld_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q      <= 1'b0;
            ld_pending_q <= 1'b0;
            ld_rd_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            opcode_q     <= '0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ld_pending_q <= ld_pending_d;
            ld_rd_q      <= ld_rd_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            imm_q        <= imm_d;
            rd_q         <= rd_d;
            opcode_q     <= opcode_d;
            illegal_q    <= illegal_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_op1     = op1_q;
    assign o_op2     = op2_q;
    assign o_imm     = imm_q;
    assign o_rd      = rd_q;
    assign o_opcode  = opcode_q;
    assign o_illegal = illegal_q;

endmodule
`default_nettype wire
